// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared types and helpers for the mesh-node router decision logic.
//   dir_t       : 3-bit output direction code (LOCAL/EAST/WEST/NORTH/SOUTH)
//   COUNT_W     : width of the forwarded-transfer counter
//   flit_field  : extracts a bit field from a (zero-extended) flit
//   route_dir   : dimension-ordered route decision (XY or YX)
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int COUNT_W    = 16;
    // Flits are zero-extended to this width before field extraction.
    localparam int FLIT_MAX_W = 256;

    typedef enum logic [2:0] {
        DIR_LOCAL = 3'd0,
        DIR_EAST  = 3'd1,
        DIR_WEST  = 3'd2,
        DIR_NORTH = 3'd3,
        DIR_SOUTH = 3'd4
    } dir_t;

    // Returns flit[lsb +: width] in the low bits of a 32-bit word.
    // lsb and width are expected to be elaboration-time constants.
    function automatic logic [31:0] flit_field(input logic [FLIT_MAX_W-1:0] flit,
                                               input int                    lsb,
                                               input int                    width);
        logic [FLIT_MAX_W-1:0] shifted;
        shifted = flit >> lsb;
        return shifted[31:0] & (32'hFFFF_FFFF >> (32 - width));
    endfunction

    // Coordinates are passed zero-extended to 32 bits, so the compares are
    // plain unsigned and the extremes (0, all-ones) need no special handling.
    function automatic dir_t route_dir(input logic [31:0] dst_x,
                                       input logic [31:0] dst_y,
                                       input logic [31:0] loc_x,
                                       input logic [31:0] loc_y,
                                       input logic        yx_mode);
        dir_t x_dir;
        dir_t y_dir;
        x_dir = DIR_LOCAL;
        y_dir = DIR_LOCAL;
        if (dst_x > loc_x)      x_dir = DIR_EAST;
        else if (dst_x < loc_x) x_dir = DIR_WEST;
        if (dst_y > loc_y)      y_dir = DIR_NORTH;
        else if (dst_y < loc_y) y_dir = DIR_SOUTH;
        if (!yx_mode) return (x_dir != DIR_LOCAL) ? x_dir : y_dir;
        else          return (y_dir != DIR_LOCAL) ? y_dir : x_dir;
    endfunction

endpackage

// File: rtl/router_xy_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter: the first set request at or after the
// pointer wins, wrapping past the top index back to 0.
//   i_req   [NUM_IN]  request vector
//   i_ptr   [SRC_W]   highest-priority index this cycle
//   o_grant [NUM_IN]  one-hot grant (all zero when no request)
//   o_idx   [SRC_W]   encoded winner index (0 when no request)
//   o_any             at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_IN = 2,
    parameter int SRC_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] i_req,
    input  logic [SRC_W-1:0]  i_ptr,
    output logic [NUM_IN-1:0] o_grant,
    output logic [SRC_W-1:0]  o_idx,
    output logic              o_any
);

    // Requests at or above the pointer; if any exist the lowest of them wins,
    // otherwise the search has wrapped and the lowest request overall wins.
    logic [NUM_IN-1:0] w_hi_req;
    logic [NUM_IN-1:0] w_sel;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_mask
        assign w_hi_req[gi] = i_req[gi] & ({1'b0, i_ptr} <= (SRC_W+1)'(gi));
    end

    assign o_any = |i_req;

    always_comb begin
        w_sel   = (|w_hi_req) ? w_hi_req : i_req;
        o_grant = '0;
        o_idx   = '0;
        // Scan downwards so the lowest set bit is the last (winning) assignment.
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (w_sel[k]) begin
                o_grant    = '0;
                o_grant[k] = 1'b1;
                o_idx      = SRC_W'(k);
            end
        end
    end

endmodule

// File: rtl/router_xy_arb.sv
// -----------------------------------------------------------------------------
// router_xy_arb
// Clocked route/arbitration stage of a mesh node: picks one of NUM_IN input
// flits per cycle (round-robin), computes its XY/YX direction against this
// node's coordinates and presents it from a single registered output stage.
//   clk, rst              clock, synchronous active-high reset
//   loc_x, loc_y          this node's coordinates
//   yx_mode               0 = X first, 1 = Y first
//   in_valid/in_ready     per-input handshake (in_ready at most one-hot)
//   in_flit               flattened flits, input i at [i*FLIT_W +: FLIT_W]
//   out_valid/out_ready   output handshake
//   out_flit/out_src/out_dir  registered winning flit, source, direction
//   fwd_count             saturating count of completed output transfers
// -----------------------------------------------------------------------------
module router_xy_arb
    import router_pkg::*;
#(
    parameter int NUM_IN    = 2,
    parameter int COORD_W   = 8,
    parameter int PAYLOAD_W = 16,
    parameter int FLIT_W    = 2*COORD_W + PAYLOAD_W,
    parameter int SRC_W     = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COORD_W-1:0]       loc_x,
    input  logic [COORD_W-1:0]       loc_y,
    input  logic                     yx_mode,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic [NUM_IN*FLIT_W-1:0] in_flit,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FLIT_W-1:0]        out_flit,
    output logic [SRC_W-1:0]         out_src,
    output logic [2:0]               out_dir,
    output logic [COUNT_W-1:0]       fwd_count
);

    logic               r_out_valid;
    logic [FLIT_W-1:0]  r_out_flit;
    logic [SRC_W-1:0]   r_out_src;
    dir_t               r_out_dir;
    logic [SRC_W-1:0]   r_rr_ptr;
    logic [COUNT_W-1:0] r_fwd_count;

    logic               w_load;
    logic [NUM_IN-1:0]  w_grant;
    logic [SRC_W-1:0]   w_win_idx;
    logic               w_any;
    logic [FLIT_W-1:0]  w_win_flit;
    logic [COORD_W-1:0] w_dst_x;
    logic [COORD_W-1:0] w_dst_y;
    dir_t               w_dir;
    logic [SRC_W-1:0]   w_ptr_next;

    // The output register can take a new flit when empty or being drained.
    assign w_load = ~r_out_valid | out_ready;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SRC_W  (SRC_W)
    ) u_arb (
        .i_req   (in_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win_idx),
        .o_any   (w_any)
    );

    assign in_ready   = (w_load & ~rst) ? w_grant : '0;
    assign w_win_flit = in_flit[w_win_idx*FLIT_W +: FLIT_W];

    assign w_dst_x = COORD_W'(flit_field(FLIT_MAX_W'(w_win_flit), COORD_W + PAYLOAD_W, COORD_W));
    assign w_dst_y = COORD_W'(flit_field(FLIT_MAX_W'(w_win_flit), PAYLOAD_W, COORD_W));
    assign w_dir   = route_dir(32'(w_dst_x), 32'(w_dst_y), 32'(loc_x), 32'(loc_y), yx_mode);

    assign w_ptr_next = (w_win_idx == SRC_W'(NUM_IN - 1)) ? '0 : w_win_idx + SRC_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_out_src   <= '0;
            r_out_dir   <= DIR_LOCAL;
            r_rr_ptr    <= '0;
            r_fwd_count <= '0;
        end else begin
            if (r_out_valid && out_ready && (r_fwd_count != '1)) begin
                r_fwd_count <= r_fwd_count + COUNT_W'(1);
            end
            if (w_load) begin
                r_out_valid <= w_any;
                // Data fields keep their last value when nothing is granted,
                // so they never go undefined.
                if (w_any) begin
                    r_out_flit <= w_win_flit;
                    r_out_src  <= w_win_idx;
                    r_out_dir  <= w_dir;
                    r_rr_ptr   <= w_ptr_next;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_flit  = r_out_flit;
    assign out_src   = r_out_src;
    assign out_dir   = 3'(r_out_dir);
    assign fwd_count = r_fwd_count;

endmodule

// File: tb/tb_router_xy_arb.sv
// -----------------------------------------------------------------------------
// tb_router_xy_arb
// Directed bench for router_xy_arb with NUM_IN=4: reset, fairness with XY
// routing, single-requester YX/edge routing, backpressure with a delivery
// scoreboard, counter saturation and reset while holding a flit.
// -----------------------------------------------------------------------------
module tb_router_xy_arb;

    localparam int NUM_IN    = 4;
    localparam int COORD_W   = 8;
    localparam int PAYLOAD_W = 16;
    localparam int FLIT_W    = 2*COORD_W + PAYLOAD_W;
    localparam int SRC_W     = 2;

    localparam logic [2:0] D_LOCAL = 3'd0;
    localparam logic [2:0] D_EAST  = 3'd1;
    localparam logic [2:0] D_WEST  = 3'd2;
    localparam logic [2:0] D_NORTH = 3'd3;
    localparam logic [2:0] D_SOUTH = 3'd4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [COORD_W-1:0]       loc_x;
    logic [COORD_W-1:0]       loc_y;
    logic                     yx_mode;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_ready;
    logic [NUM_IN*FLIT_W-1:0] in_flit;
    logic                     out_valid;
    logic                     out_ready;
    logic [FLIT_W-1:0]        out_flit;
    logic [SRC_W-1:0]         out_src;
    logic [2:0]               out_dir;
    logic [15:0]              fwd_count;

    always #5 clk = ~clk;

    router_xy_arb #(
        .NUM_IN    (NUM_IN),
        .COORD_W   (COORD_W),
        .PAYLOAD_W (PAYLOAD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .loc_x     (loc_x),
        .loc_y     (loc_y),
        .yx_mode   (yx_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_flit   (in_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_flit  (out_flit),
        .out_src   (out_src),
        .out_dir   (out_dir),
        .fwd_count (fwd_count)
    );

    int n_cmp = 0;
    int n_err = 0;
    int exp_fwd = 0;
    logic [FLIT_W-1:0] got_q[$];

    // Records every completed output transfer.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back(out_flit);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [FLIT_W-1:0] mk_flit(input logic [7:0] dx, input logic [7:0] dy,
                                                  input logic [15:0] pl);
        return {dx, dy, pl};
    endfunction

    task automatic set_flit(input int idx, input logic [FLIT_W-1:0] f);
        in_flit[idx*FLIT_W +: FLIT_W] = f;
    endtask

    // Single-requester transaction; called right after a negedge with out_valid=0.
    task automatic send_one(input string tag, input int idx, input logic [FLIT_W-1:0] f,
                            input logic [2:0] exp_dir);
        logic [NUM_IN-1:0] onehot;
        onehot = NUM_IN'(1) << idx;
        set_flit(idx, f);
        in_valid  = onehot;
        out_ready = 1'b1;
        #1 check_val({tag, "_rdy"}, 64'(in_ready), 64'(onehot));
        @(negedge clk);
        check_val({tag, "_vld"}, 64'(out_valid), 64'd1);
        check_val({tag, "_src"}, 64'(out_src), 64'(idx));
        check_val({tag, "_dir"}, 64'(out_dir), 64'(exp_dir));
        check_val({tag, "_flit"}, 64'(out_flit), 64'(f));
        in_valid = '0;
        @(negedge clk);
        exp_fwd++;
        check_val({tag, "_drain"}, 64'(out_valid), 64'd0);
        check_val({tag, "_fwd"}, 64'(fwd_count), 64'(exp_fwd));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FLIT_W-1:0] f[4];
        logic [2:0]        d[4];
        logic [FLIT_W-1:0] fa;
        logic [FLIT_W-1:0] fb;
        logic [FLIT_W-1:0] fs;
        int                cycles;

        rst = 1'b1; in_valid = '1; out_ready = 1'b1; yx_mode = 1'b0;
        loc_x = 8'd5; loc_y = 8'd5; in_flit = '0;
        f[0] = mk_flit(8'd7, 8'd2, 16'h1000); d[0] = D_EAST;
        f[1] = mk_flit(8'd5, 8'd2, 16'h1001); d[1] = D_SOUTH;
        f[2] = mk_flit(8'd5, 8'd5, 16'h1002); d[2] = D_LOCAL;
        f[3] = mk_flit(8'd0, 8'd9, 16'h1003); d[3] = D_WEST;
        for (int i = 0; i < NUM_IN; i++) set_flit(i, f[i]);

        // Reset held for two cycles with every input requesting.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_val("rst_ready", 64'(in_ready), 64'd0);
            check_val("rst_valid", 64'(out_valid), 64'd0);
            check_val("rst_fwd", 64'(fwd_count), 64'd0);
        end
        rst = 1'b0;
        #1 check_val("first_grant", 64'(in_ready), 64'b0001);

        // Fairness with XY routing from (5,5).
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_val("fair_vld", 64'(out_valid), 64'd1);
            check_val("fair_src", 64'(out_src), 64'(k % 4));
            check_val("fair_flit", 64'(out_flit), 64'(f[k % 4]));
            check_val("fair_dir", 64'(out_dir), 64'(d[k % 4]));
            check_val("fair_rdy", 64'(in_ready), 64'(NUM_IN'(1) << ((k + 1) % 4)));
            if (k == 7) in_valid = '0;
        end
        @(negedge clk);
        exp_fwd = 8;
        check_val("fair_drain", 64'(out_valid), 64'd0);
        check_val("fair_fwd", 64'(fwd_count), 64'd8);

        // Single requesters; pointer starts at 0, index 0 after ptr=2 wraps.
        yx_mode = 1'b1; loc_x = 8'd5; loc_y = 8'd5;
        send_one("yx_south", 1, mk_flit(8'd7, 8'd2, 16'h2001), D_SOUTH);
        send_one("yx_east_wrap", 0, mk_flit(8'd7, 8'd5, 16'h2002), D_EAST);
        loc_x = 8'd255; loc_y = 8'd0;
        send_one("yx_edge_north", 3, mk_flit(8'd255, 8'd255, 16'h2003), D_NORTH);
        yx_mode = 1'b0; loc_x = 8'd0; loc_y = 8'd255;
        send_one("xy_edge_east", 2, mk_flit(8'd255, 8'd0, 16'h2004), D_EAST);
        loc_x = 8'd255; loc_y = 8'd255;
        send_one("xy_edge_west", 1, mk_flit(8'd0, 8'd0, 16'h2005), D_WEST);

        // Backpressure: pointer is now 2, inputs 1 and 3 request.
        loc_x = 8'd5; loc_y = 8'd5; yx_mode = 1'b0;
        fa = mk_flit(8'd5, 8'd9, 16'hA001);
        fb = mk_flit(8'd3, 8'd5, 16'hA003);
        set_flit(1, fa); set_flit(3, fb);
        got_q.delete();
        in_valid = 4'b1010; out_ready = 1'b0;
        #1 check_val("bp_first_rdy", 64'(in_ready), 64'b1000);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_val("bp_hold_vld", 64'(out_valid), 64'd1);
            check_val("bp_hold_src", 64'(out_src), 64'd3);
            check_val("bp_hold_flit", 64'(out_flit), 64'(fb));
            check_val("bp_hold_dir", 64'(out_dir), 64'(D_WEST));
            check_val("bp_hold_rdy", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1 check_val("bp_release_rdy", 64'(in_ready), 64'b0010);
        @(negedge clk);
        check_val("bp_next_src", 64'(out_src), 64'd1);
        check_val("bp_next_flit", 64'(out_flit), 64'(fa));
        check_val("bp_next_dir", 64'(out_dir), 64'(D_NORTH));
        in_valid = '0;
        @(negedge clk);
        exp_fwd += 2;
        check_val("bp_drain", 64'(out_valid), 64'd0);
        check_val("bp_sb_count", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            check_val("bp_sb_0", 64'(got_q[0]), 64'(fb));
            check_val("bp_sb_1", 64'(got_q[1]), 64'(fa));
        end
        check_val("bp_fwd", 64'(fwd_count), 64'(exp_fwd));

        // Saturation: stream from input 0 until the counter tops out.
        set_flit(0, mk_flit(8'd9, 8'd5, 16'h5A5A));
        in_valid = 4'b0001; out_ready = 1'b1;
        cycles = 0;
        while (fwd_count != 16'hFFFF && cycles < 70000) begin
            @(negedge clk);
            cycles++;
        end
        check_val("sat_reach", 64'(fwd_count), 64'hFFFF);
        check_val("sat_vld", 64'(out_valid), 64'd1);
        @(negedge clk);
        check_val("sat_hold", 64'(fwd_count), 64'hFFFF);

        // Reset while holding a flit: that flit must never be delivered.
        fs = mk_flit(8'd1, 8'd2, 16'hBEEF);
        set_flit(0, fs);
        @(negedge clk);
        out_ready = 1'b0; in_valid = '0;
        check_val("mid_held_flit", 64'(out_flit), 64'(fs));
        got_q.delete();
        rst = 1'b1; in_valid = '1;
        #1 check_val("mid_rst_rdy", 64'(in_ready), 64'd0);
        @(negedge clk);
        check_val("mid_rst_vld", 64'(out_valid), 64'd0);
        check_val("mid_rst_flit", 64'(out_flit), 64'd0);
        check_val("mid_rst_fwd", 64'(fwd_count), 64'd0);
        rst = 1'b0; out_ready = 1'b1; in_valid = 4'b1001;
        #1 check_val("mid_rst_ptr", 64'(in_ready), 64'b0001);
        in_valid = '0;
        repeat (3) @(negedge clk);
        check_val("mid_no_deliver", 64'(got_q.size()), 64'd0);
        check_val("mid_idle_vld", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/router_xy_arb.md
Name: router_xy_arb

Overview:
- Parametrised, clocked successor to the team's combinational router decision logic.
- Accepts flits from NUM_IN requesters, each with valid/ready. Picks one per cycle with round-robin arbitration.
- Computes the dimension-ordered route direction (XY or YX, runtime-selectable) against the node's own coordinates.
- Presents the winning flit, its source index and direction from a single registered output stage with valid/ready backpressure. Sits between input FIFOs and the crossbar of a mesh node.

Parameters:
- NUM_IN, 2, number of requesting input ports (≥2)
- COORD_W, 8, width of each unsigned coordinate (X and Y)
- PAYLOAD_W, 16, payload width carried untouched
- FLIT_W, 2*COORD_W+PAYLOAD_W, derived; flit = {dst_x, dst_y, payload}, dst_x in MSBs
- SRC_W, $clog2(NUM_IN), derived source-index width

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- loc_x  in  COORD_W  this node's X coordinate; sampled every cycle
- loc_y  in  COORD_W  this node's Y coordinate; sampled every cycle
- yx_mode  in  1  0 = route X first, 1 = route Y first
- in_valid  in  NUM_IN  per-input flit valid
- in_ready  out  NUM_IN  per-input accept; at most one bit high per cycle
- in_flit  in  NUM_IN*FLIT_W  flattened flits; input i at bits [i*FLIT_W +: FLIT_W]
- out_valid  out  1  registered flit available
- out_ready  in  1  downstream accept
- out_flit  out  FLIT_W  winning flit, unmodified
- out_src  out  SRC_W  index of the winning input
- out_dir  out  3  0 LOCAL, 1 EAST, 2 WEST, 3 NORTH, 4 SOUTH; 5–7 never produced
- fwd_count  out  16  saturating count of completed output transfers

Behaviour:
- Reset state:
  - out_valid=0; out_flit, out_src, out_dir, fwd_count all 0.
  - rr_ptr=0, so input 0 has highest priority on the first arbitration.
  - in_ready is combinational and is 0 while rst=1.
- Capture enable: load = ~out_valid | out_ready. This gives full throughput: one flit per cycle when out_ready is held high.
- Arbitration (combinational):
  - Search in_valid starting at rr_ptr, wrapping modulo NUM_IN; the first set bit wins.
  - in_ready[w] = load & in_valid[w]. All other in_ready bits are 0.
  - No grant when in_valid=0.
- Transfer on input w in cycle t:
  - out_flit, out_src=w and out_dir are registered at edge t+1.
  - out_valid=1 from t+1. Latency is 1 cycle.
  - rr_ptr ← (w+1) mod NUM_IN.
  - rr_ptr does not change when no grant occurs.
- Output holding: while out_valid & ~out_ready, out_flit/out_src/out_dir are held stable and all in_ready are 0.
- Output drain: if out_valid & out_ready and no new grant, out_valid→0 next cycle.
- Direction, computed from the granted flit with unsigned compares:
  - XY mode: dst_x>loc_x → EAST; dst_x<loc_x → WEST; else dst_y>loc_y → NORTH; dst_y<loc_y → SOUTH; else LOCAL.
  - YX mode: Y is checked first (NORTH/SOUTH), then X.
  - yx_mode and loc_x/loc_y are sampled in the grant cycle. A change mid-stream affects only later grants.
- fwd_count: increments on every cycle with out_valid & out_ready. It saturates at 16'hFFFF and does not wrap.
- Boundary cases:
  - Coordinates at 0 or 2^COORD_W-1 compare correctly, with no overflow.
  - If rr_ptr points at an idle input, the search wraps.
  - With a single requester, that requester wins every cycle.
- Reset mid-operation: any held output flit is discarded, out_valid→0, and rr_ptr→0 on the next edge. in_ready is 0 during reset, so no input is acknowledged.
- No X-propagation: out_flit/out_src/out_dir must be defined values even when out_valid=0.

Decomposition:
- Shared package router_pkg holds:
  - a dir_t enum (LOCAL, EAST, WEST, NORTH, SOUTH; 3 bits)
  - a flit field-extraction function or macro-free slice helper
  - COUNT_W=16
- One natural sub-module: rr_arbiter (NUM_IN-wide request vector, pointer, one-hot grant, encoded index). It is reusable by the crossbar output stages.
- Route compute stays inline as a function in router_pkg (route_dir(dst_x,dst_y,loc_x,loc_y,yx_mode)).

Test Plan:
- Reset: assert rst for 2 cycles with all in_valid=1 → in_ready=0, out_valid=0 and fwd_count=0 throughout; first grant after release goes to input 0.
- Route XY: loc=(5,5), yx_mode=0, dst=(7,2) → out_dir=EAST. dst=(5,2) → SOUTH. dst=(5,5) → LOCAL. dst=(0,9) → WEST.
- Route YX: loc=(5,5), yx_mode=1, dst=(7,2) → SOUTH. dst=(7,5) → EAST. Edge check: loc=(255,0), dst=(255,255) → NORTH.
- Fairness: NUM_IN=4, all in_valid=1, out_ready=1 for 8 cycles → out_src sequence 0,1,2,3,0,1,2,3, one flit per cycle, fwd_count=8.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 → out_flit/out_src/out_dir stable and in_ready=0; on release, the held flit transfers and the next grant lands the following cycle. No loss or duplication, checked by a scoreboard.
- Saturation and reset: preload traffic to 65535 transfers, one more transfer → fwd_count stays 16'hFFFF. Assert rst while holding a flit → out_valid=0 next cycle and that flit is never delivered.
